// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath widths and register-file types.
package rv32i_pkg;

    localparam int unsigned DPW        = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DPW-1:0]        word_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : rv32i_pkg

// File: rtl/regfile_array.sv
// Integer register storage: one write port, two write-through read ports, x0 hardwired.
module regfile_array
    import rv32i_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t wa,
    input  word_t     wd,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    output word_t     rd1_c,
    output word_t     rd2_c
);

    word_t regs [NREGS];

    // Entry 0 is cleared on reset and never written afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != ZERO_REG)) begin
            regs[wa] <= wd;
        end
    end

    function automatic word_t readPort(input reg_addr_t ra, input word_t stored);
        if (ra == ZERO_REG) begin
            return '0;
        end else if (we && (wa == ra)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        rd1_c = readPort(ra1, regs[ra1]);
        rd2_c = readPort(ra2, regs[ra2]);
    end

endmodule : regfile_array

// File: rtl/regfile_decode_stage.sv
// Register file plus D->E pipeline register with stall, flush and operand refresh.
module regfile_decode_stage
    import rv32i_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      regwriteW,
    input  reg_addr_t RdW,
    input  word_t     resultW,
    input  reg_addr_t Rs1D,
    input  reg_addr_t Rs2D,
    input  reg_addr_t RdD,
    input  logic      stallE,
    input  logic      flushE,
    output word_t     RD1E,
    output word_t     RD2E,
    output reg_addr_t Rs1E,
    output reg_addr_t Rs2E,
    output reg_addr_t RdE
);

    word_t rd1D;
    word_t rd2D;
    logic  refresh1;
    logic  refresh2;

    regfile_array uArray (
        .clk   (clk),
        .rst   (rst),
        .we    (regwriteW),
        .wa    (RdW),
        .wd    (resultW),
        .ra1   (Rs1D),
        .ra2   (Rs2D),
        .rd1_c (rd1D),
        .rd2_c (rd2D)
    );

    // A held operand picks up a writeback to its own source so it never goes stale.
    always_comb begin
        refresh1 = regwriteW && (RdW == Rs1E) && (Rs1E != ZERO_REG);
        refresh2 = regwriteW && (RdW == Rs2E) && (Rs2E != ZERO_REG);
    end

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            RD1E <= '0;
            RD2E <= '0;
            Rs1E <= '0;
            Rs2E <= '0;
            RdE  <= '0;
        end else if (stallE) begin
            if (refresh1) begin
                RD1E <= resultW;
            end
            if (refresh2) begin
                RD2E <= resultW;
            end
        end else begin
            RD1E <= rd1D;
            RD2E <= rd2D;
            Rs1E <= Rs1D;
            Rs2E <= Rs2D;
            RdE  <= RdD;
        end
    end

endmodule : regfile_decode_stage

// File: tb/tb_regfile_decode_stage.sv
// Directed and randomized checks of the register file and D->E register.
module tb_regfile_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteW;
    logic [4:0]  RdW;
    logic [31:0] resultW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic        stallE;
    logic        flushE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] refRegs [32];
    logic [31:0] expRd1, expRd2;
    logic [4:0]  expRs1, expRs2, expRd;

    always #5 clk = ~clk;

    regfile_decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .regwriteW (regwriteW),
        .RdW       (RdW),
        .resultW   (resultW),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .stallE    (stallE),
        .flushE    (flushE),
        .RD1E      (RD1E),
        .RD2E      (RD2E),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; regwriteW = 1'b0; RdW = '0; resultW = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0; stallE = 1'b0; flushE = 1'b0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (regwriteW && RdW == rs) return resultW;
        return refRegs[rs];
    endfunction

    // Reference behaviour evaluated on the current inputs, before the clock edge.
    task automatic modelStep();
        if (rst || flushE) begin
            expRd1 = '0; expRd2 = '0; expRs1 = '0; expRs2 = '0; expRd = '0;
        end else if (stallE) begin
            if (regwriteW && RdW == expRs1 && expRs1 != 5'd0) expRd1 = resultW;
            if (regwriteW && RdW == expRs2 && expRs2 != 5'd0) expRd2 = resultW;
        end else begin
            expRd1 = modelRead(Rs1D);
            expRd2 = modelRead(Rs2D);
            expRs1 = Rs1D; expRs2 = Rs2D; expRd = RdD;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) refRegs[i] = '0;
        end else if (regwriteW && RdW != 5'd0) begin
            refRegs[RdW] = resultW;
        end
    endtask

    initial begin
        idle();
        rst = 1'b1; regwriteW = 1'bx; RdW = 'x; resultW = 'x;
        Rs1D = 'x; Rs2D = 'x; RdD = 'x; stallE = 1'bx; flushE = 1'bx;
        tick(); tick();
        checkEq("reset RD1E", RD1E, 32'h0);
        checkEq("reset RD2E", RD2E, 32'h0);
        checkEq("reset RdE", 32'(RdE), 32'h0);

        idle(); Rs1D = 5'd5; Rs2D = 5'd31; RdD = 5'd12;
        tick();
        checkEq("read x5 after reset", RD1E, 32'h0);
        checkEq("read x31 after reset", RD2E, 32'h0);
        checkEq("Rs2E capture", 32'(Rs2E), 32'd31);
        checkEq("RdE capture", 32'(RdE), 32'd12);

        idle(); regwriteW = 1'b1; RdW = 5'd7; resultW = 32'hDEAD_BEEF;
        tick();
        idle(); Rs1D = 5'd7;
        tick();
        checkEq("x7 readback", RD1E, 32'hDEAD_BEEF);

        idle(); regwriteW = 1'b1; RdW = 5'd3; resultW = 32'h1234; Rs1D = 5'd3; Rs2D = 5'd3;
        tick();
        checkEq("bypass RD1E", RD1E, 32'h1234);
        checkEq("bypass RD2E", RD2E, 32'h1234);

        idle(); regwriteW = 1'b1; RdW = 5'd0; resultW = 32'hFFFF_FFFF; Rs1D = 5'd0; Rs2D = 5'd0;
        tick();
        checkEq("x0 write ignored bypass", RD1E, 32'h0);
        idle();
        tick();
        checkEq("x0 later read", RD1E, 32'h0);
        checkEq("x0 later read p2", RD2E, 32'h0);

        idle(); Rs1D = 5'd9; Rs2D = 5'd10; RdD = 5'd2;
        tick();
        checkEq("pre-stall Rs1E", 32'(Rs1E), 32'd9);
        idle(); stallE = 1'b1; Rs1D = 5'd1; Rs2D = 5'd1; RdD = 5'd1;
        regwriteW = 1'b1; RdW = 5'd9; resultW = 32'h0000_A5A5;
        tick();
        checkEq("stall refresh RD1E", RD1E, 32'h0000_A5A5);
        checkEq("stall holds Rs1E", 32'(Rs1E), 32'd9);
        checkEq("stall holds RdE", 32'(RdE), 32'd2);
        RdW = 5'd10; resultW = 32'h0000_1111;
        tick();
        checkEq("stall other reg RD1E", RD1E, 32'h0000_A5A5);
        checkEq("stall refresh RD2E", RD2E, 32'h0000_1111);

        idle(); stallE = 1'b1; flushE = 1'b1; Rs1D = 5'd7;
        tick();
        checkEq("flush RD1E", RD1E, 32'h0);
        checkEq("flush RD2E", RD2E, 32'h0);
        checkEq("flush Rs1E", 32'(Rs1E), 32'h0);
        checkEq("flush Rs2E", 32'(Rs2E), 32'h0);
        checkEq("flush RdE", 32'(RdE), 32'h0);

        idle(); rst = 1'b1; stallE = 1'b1; regwriteW = 1'b1; RdW = 5'd4; resultW = 32'h4444_4444;
        tick();
        idle(); Rs1D = 5'd4; Rs2D = 5'd7;
        tick();
        checkEq("x4 write dropped in reset", RD1E, 32'h0);
        checkEq("x7 cleared by reset", RD2E, 32'h0);

        // Randomized traffic against the reference model, reset state assumed all-zero.
        for (int i = 0; i < 32; i++) refRegs[i] = '0;
        expRd1 = RD1E; expRd2 = RD2E; expRs1 = 5'd4; expRs2 = 5'd7; expRd = 5'd0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            rst       = ($urandom_range(199) == 0);
            regwriteW = ($urandom_range(3) != 0);
            RdW       = 5'($urandom_range(31));
            resultW   = $urandom;
            Rs1D      = ($urandom_range(3) == 0) ? RdW : 5'($urandom_range(31));
            Rs2D      = 5'($urandom_range(31));
            RdD       = 5'($urandom_range(31));
            stallE    = ($urandom_range(7) == 0);
            flushE    = ($urandom_range(15) == 0);
            modelStep();
            tick();
            checkEq("rand RD1E", RD1E, expRd1);
            checkEq("rand RD2E", RD2E, expRd2);
            checkEq("rand Rs1E", 32'(Rs1E), 32'(expRs1));
            checkEq("rand Rs2E", 32'(Rs2E), 32'(expRs2));
            checkEq("rand RdE", 32'(RdE), 32'(expRd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_regfile_decode_stage
